// File: rtl/feature_deserializer_pkg.sv
// -----------------------------------------------------------------------------
// feature_deserializer_pkg
//   Shared sizing constants and helpers for the sensor-fusion input stage.
//   TOTAL_NUM_CHANNEL     : channels per frame delivered to the fusion core
//   DEFAULT_CHANNEL_WIDTH : bits per channel feature
//   ceil_log2()           : constant function, bits needed to count 0..value-1
// -----------------------------------------------------------------------------
package feature_deserializer_pkg;

  localparam int TOTAL_NUM_CHANNEL     = 214;
  localparam int DEFAULT_CHANNEL_WIDTH = 2;

  function automatic int ceil_log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/feature_deserializer.sv
// -----------------------------------------------------------------------------
// feature_deserializer
//   Collects NUM_CHANNEL serial feature beats into one frame for the fusion
//   core. sin_first marks channel 0 and keeps the block frame-aligned; any
//   beat that breaks alignment raises a one-cycle frame_error pulse.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   sin_valid     : input beat valid
//   sin_ready     : beat accepted when sin_valid && sin_ready (low only in HOLD)
//   sin_data      : feature of the current channel
//   sin_first     : beat is channel 0 of a frame
//   dout_valid    : assembled frame available (core fin_valid)
//   dout_ready    : core fin_ready
//   features_top  : assembled frame, channel 0 in the MSBs
//   frame_error   : one-cycle pulse per framing violation
// -----------------------------------------------------------------------------
module feature_deserializer
  import feature_deserializer_pkg::*;
#(
  parameter int NUM_CHANNEL   = TOTAL_NUM_CHANNEL,
  parameter int CHANNEL_WIDTH = DEFAULT_CHANNEL_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 sin_valid,
  output logic                                 sin_ready,
  input  logic [CHANNEL_WIDTH-1:0]             sin_data,
  input  logic                                 sin_first,
  output logic                                 dout_valid,
  input  logic                                 dout_ready,
  output logic [NUM_CHANNEL*CHANNEL_WIDTH-1:0] features_top,
  output logic                                 frame_error
);

  localparam int                FRAME_W = NUM_CHANNEL * CHANNEL_WIDTH;
  localparam int                CNT_W   = ceil_log2(NUM_CHANNEL);
  localparam logic [CNT_W-1:0]  LAST_CH = CNT_W'(NUM_CHANNEL - 1);
  localparam logic [CNT_W-1:0]  ONE_CH  = CNT_W'(1);

  typedef enum logic [1:0] {HUNT, FILL, HOLD} state_t;

  state_t             state;
  logic [CNT_W-1:0]   ch_cnt;
  logic [FRAME_W-1:0] asm_p0;
  logic [FRAME_W-1:0] asm_next;
  logic [CNT_W-1:0]   slot;
  logic               accept;
  logic               out_free;
  logic               is_last;

  // Writes one beat into its channel slot; channel 0 lands in the MSBs.
  function automatic logic [FRAME_W-1:0] insert_beat(
    input logic [FRAME_W-1:0]       frame,
    input logic [CNT_W-1:0]         ch,
    input logic [CHANNEL_WIDTH-1:0] beat
  );
    logic [FRAME_W-1:0] f;
    f = frame;
    f[(NUM_CHANNEL - 1 - int'(ch)) * CHANNEL_WIDTH +: CHANNEL_WIDTH] = beat;
    return f;
  endfunction

  // Ready comes from registered state only, so no input-to-ready path.
  assign sin_ready = (state != HOLD);
  assign accept    = sin_valid && sin_ready;
  assign out_free  = !dout_valid || dout_ready;
  // A sin_first beat always restarts at channel 0, whatever the state.
  assign slot      = (state == FILL && !sin_first) ? ch_cnt : '0;
  assign is_last   = (state == FILL) && !sin_first && (ch_cnt == LAST_CH);
  assign asm_next  = insert_beat(asm_p0, slot, sin_data);

  // Stage p0: assembly register / stage p1: output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= HUNT;
      ch_cnt       <= '0;
      asm_p0       <= '0;
      features_top <= '0;
      dout_valid   <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      // Drain clears valid; a load below in the same edge overrides it.
      if (dout_valid && dout_ready) dout_valid <= 1'b0;

      case (state)
        HUNT: begin
          if (accept) begin
            if (sin_first) begin
              asm_p0 <= asm_next;
              ch_cnt <= ONE_CH;
              state  <= FILL;
            end else begin
              frame_error <= 1'b1;
            end
          end
        end

        FILL: begin
          if (accept) begin
            asm_p0 <= asm_next;
            if (sin_first) begin
              frame_error <= 1'b1;
              ch_cnt      <= ONE_CH;
            end else if (is_last) begin
              ch_cnt <= '0;
              if (out_free) begin
                // Bypass: the final beat goes straight into the output frame.
                features_top <= asm_next;
                dout_valid   <= 1'b1;
                state        <= HUNT;
              end else begin
                state <= HOLD;
              end
            end else begin
              ch_cnt <= ch_cnt + ONE_CH;
            end
          end
        end

        HOLD: begin
          if (out_free) begin
            features_top <= asm_p0;
            dout_valid   <= 1'b1;
            state        <= HUNT;
          end
        end

        default: state <= HUNT;
      endcase
    end
  end

endmodule
